// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one downstream memory port among NR_REQ requesters. Arbitration is
//   round-robin and only one transaction is outstanding at a time. The grant is
//   held from acceptance until the response handshake. The granted index selects
//   the request payload and routes the response.
//
// Ports
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester request handshake (ready only in IDLE)
//   req_addr/wen/wdata/wmask   packed per-requester payload, slot i at [W*(i+1)-1 : W*i]
//   resp_valid/resp_ready      per-requester response handshake, routed to the grant
//   resp_rdata                 read data, broadcast to every requester
//   m_req_valid/m_req_ready    downstream request handshake
//   m_addr/wen/wdata/wmask     registered downstream payload
//   m_resp_valid/m_resp_ready  downstream response handshake
//   m_rdata                    downstream read data
//   busy                       a transaction is in flight
//   gnt_idx                    current or most recent grant
module mem_port_arbiter #(
    parameter int  NR_REQ = 2,
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 32,
    localparam int GW     = (NR_REQ > 1) ? $clog2(NR_REQ) : 1,
    localparam int MW     = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NR_REQ-1:0]        req_valid,
    output logic [NR_REQ-1:0]        req_ready,
    input  logic [NR_REQ*ADDR_W-1:0] req_addr,
    input  logic [NR_REQ-1:0]        req_wen,
    input  logic [NR_REQ*DATA_W-1:0] req_wdata,
    input  logic [NR_REQ*MW-1:0]     req_wmask,
    output logic [NR_REQ-1:0]        resp_valid,
    input  logic [NR_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]        resp_rdata,
    output logic                     m_req_valid,
    input  logic                     m_req_ready,
    output logic [ADDR_W-1:0]        m_addr,
    output logic                     m_wen,
    output logic [DATA_W-1:0]        m_wdata,
    output logic [MW-1:0]            m_wmask,
    input  logic                     m_resp_valid,
    output logic                     m_resp_ready,
    input  logic [DATA_W-1:0]        m_rdata,
    output logic                     busy,
    output logic [GW-1:0]            gnt_idx
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [GW-1:0]       r_ptr;
    logic [GW-1:0]       r_gnt_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [MW-1:0]       r_wmask;
    logic                r_m_req_valid;
    logic                r_busy;

    logic                w_found;
    logic [GW-1:0]       w_winner;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_wen;
    logic [DATA_W-1:0]   w_wdata;
    logic [MW-1:0]       w_wmask;
    logic [NR_REQ-1:0]   w_gnt_onehot;
    logic                w_in_wait;
    logic                w_m_resp_ready;
    logic                w_resp_hs;

    // Round-robin winner: first valid at or above ptr, otherwise first valid below ptr
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (!w_found && req_valid[i] && (GW'(i) >= r_ptr)) begin
                w_found  = 1'b1;
                w_winner = GW'(i);
            end else begin
                w_found  = w_found;
            end
        end
        for (int i = 0; i < NR_REQ; i++) begin
            if (!w_found && req_valid[i] && (GW'(i) < r_ptr)) begin
                w_found  = 1'b1;
                w_winner = GW'(i);
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Payload mux steered by the winner, captured at acceptance
    always_comb begin
        w_addr  = '0;
        w_wen   = 1'b0;
        w_wdata = '0;
        w_wmask = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (w_winner == GW'(i)) begin
                w_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_wen   = req_wen[i];
                w_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_wmask = req_wmask[i*MW +: MW];
            end else begin
                w_wen   = w_wen;
            end
        end
    end

    // Request ready and response routing; rst_n gates ready so nothing is accepted in reset
    always_comb begin
        w_in_wait = (r_state == ST_WAIT_RESP);
        for (int i = 0; i < NR_REQ; i++) begin
            w_gnt_onehot[i] = (r_gnt_idx == GW'(i));
            req_ready[i]    = rst_n && (r_state == ST_IDLE) && w_found && (w_winner == GW'(i));
            resp_valid[i]   = w_in_wait && m_resp_valid && w_gnt_onehot[i];
        end
        w_m_resp_ready = w_in_wait && (|(resp_ready & w_gnt_onehot));
        w_resp_hs      = w_m_resp_ready && m_resp_valid;
    end

    // Arbitration FSM: grant, pointer, payload and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_gnt_idx     <= '0;
            r_addr        <= '0;
            r_wen         <= 1'b0;
            r_wdata       <= '0;
            r_wmask       <= '0;
            r_m_req_valid <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt_idx     <= w_winner;
                        r_addr        <= w_addr;
                        r_wen         <= w_wen;
                        r_wdata       <= w_wdata;
                        r_wmask       <= w_wmask;
                        r_m_req_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= ST_ISSUE;
                    end else begin
                        r_state       <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (m_req_ready) begin
                        r_m_req_valid <= 1'b0;
                        r_state       <= ST_WAIT_RESP;
                    end else begin
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_WAIT_RESP: begin
                    if (w_resp_hs) begin
                        // Explicit wrap so non-power-of-two requester counts work
                        r_ptr   <= (r_gnt_idx == GW'(NR_REQ - 1)) ? '0 : r_gnt_idx + GW'(1);
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_RESP;
                    end
                end
                default: begin
                    r_m_req_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_req_valid  = r_m_req_valid;
    assign m_addr       = r_addr;
    assign m_wen        = r_wen;
    assign m_wdata      = r_wdata;
    assign m_wmask      = r_wmask;
    assign m_resp_ready = w_m_resp_ready;
    assign resp_rdata   = m_rdata;
    assign busy         = r_busy;
    assign gnt_idx      = r_gnt_idx;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter with three requesters (non-power-of-two wrap).
// A transaction-level model predicts every output; directed scenarios add
// hand-computed literal expectations.
module tb_mem_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_wen = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*MW-1:0] req_wmask = '0;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready = '0;
    logic [DW-1:0]   resp_rdata;
    logic            m_req_valid;
    logic            m_req_ready = 1'b0;
    logic [AW-1:0]   m_addr;
    logic            m_wen;
    logic [DW-1:0]   m_wdata;
    logic [MW-1:0]   m_wmask;
    logic            m_resp_valid = 1'b0;
    logic            m_resp_ready;
    logic [DW-1:0]   m_rdata = '0;
    logic            busy;
    logic [GW-1:0]   gnt_idx;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NR_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
        .m_wen(m_wen), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_rdata(m_rdata),
        .busy(busy), .gnt_idx(gnt_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 = waiting for a request, 1 = request offered downstream, 2 = awaiting response
    int              mdl_phase;
    int              mdl_ptr;
    int              mdl_gnt;
    logic [AW-1:0]   mdl_addr;
    logic            mdl_wen;
    logic [DW-1:0]   mdl_wdata;
    logic [MW-1:0]   mdl_wmask;

    function automatic int winner(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (((v >> ((p + k) % N)) & N'(1)) != '0) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] slot_addr(input int w);
        return AW'(req_addr >> (w * AW));
    endfunction
    function automatic logic [DW-1:0] slot_wdata(input int w);
        return DW'(req_wdata >> (w * DW));
    endfunction
    function automatic logic [MW-1:0] slot_wmask(input int w);
        return MW'(req_wmask >> (w * MW));
    endfunction
    function automatic logic bit_of(input logic [N-1:0] v, input int w);
        return ((v >> w) & N'(1)) != '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_phase <= 0;
            mdl_ptr   <= 0;
            mdl_gnt   <= 0;
            mdl_addr  <= '0;
            mdl_wen   <= 1'b0;
            mdl_wdata <= '0;
            mdl_wmask <= '0;
        end else if (mdl_phase == 0) begin
            if (winner(req_valid, mdl_ptr) >= 0) begin
                mdl_gnt   <= winner(req_valid, mdl_ptr);
                mdl_addr  <= slot_addr(winner(req_valid, mdl_ptr));
                mdl_wen   <= bit_of(req_wen, winner(req_valid, mdl_ptr));
                mdl_wdata <= slot_wdata(winner(req_valid, mdl_ptr));
                mdl_wmask <= slot_wmask(winner(req_valid, mdl_ptr));
                mdl_phase <= 1;
            end
        end else if (mdl_phase == 1) begin
            if (m_req_ready) mdl_phase <= 2;
        end else begin
            if (m_resp_valid && bit_of(resp_ready, mdl_gnt)) begin
                mdl_ptr   <= (mdl_gnt + 1) % N;
                mdl_phase <= 0;
            end
        end
    end

    function automatic logic [N-1:0] exp_req_ready();
        int w;
        if (!rst_n || mdl_phase != 0) return '0;
        w = winner(req_valid, mdl_ptr);
        if (w < 0) return '0;
        return N'(1) << w;
    endfunction

    function automatic logic [N-1:0] exp_resp_valid();
        if (rst_n && mdl_phase == 2 && m_resp_valid) return N'(1) << mdl_gnt;
        return '0;
    endfunction

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("req_ready",    64'(req_ready),    64'(exp_req_ready()));
        check("resp_valid",   64'(resp_valid),   64'(exp_resp_valid()));
        check("m_resp_ready", 64'(m_resp_ready),
              64'(rst_n && mdl_phase == 2 && bit_of(resp_ready, mdl_gnt)));
        check("m_req_valid",  64'(m_req_valid),  64'(mdl_phase == 1));
        check("busy",         64'(busy),         64'(mdl_phase != 0));
        check("gnt_idx",      64'(gnt_idx),      64'(mdl_gnt));
        check("m_addr",       64'(m_addr),       64'(mdl_addr));
        check("m_wen",        64'(m_wen),        64'(mdl_wen));
        check("m_wdata",      64'(m_wdata),      64'(mdl_wdata));
        check("m_wmask",      64'(m_wmask),      64'(mdl_wmask));
        check("resp_rdata",   64'(resp_rdata),   64'(m_rdata));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0; req_wen = '0; m_req_ready = 1'b0; m_resp_valid = 1'b0; resp_ready = '0;
        repeat (2) cyc();
        rst_n = 1'b1;
    endtask

    // Zero-wait memory until the arbiter goes idle, bounded by a cycle budget
    task automatic drain(input string name, input int budget);
        bit done = 1'b0;
        req_valid = '0; req_wen = '0;
        m_req_ready = 1'b1; m_resp_valid = 1'b1; resp_ready = '1;
        for (int i = 0; i < budget && !done; i++) begin
            cyc();
            @(negedge clk);
            done = !busy;
        end
        check(name, 64'(done), 64'd1);
        m_resp_valid = 1'b0;
    endtask

    int grants[$];
    int exp_grants[4] = '{0, 1, 0, 1};

    initial begin
        do_reset();
        @(negedge clk);
        check("reset_busy",     64'(busy),        64'd0);
        check("reset_gnt",      64'(gnt_idx),     64'd0);
        check("reset_m_req_v",  64'(m_req_valid), 64'd0);
        cyc();

        // 1. single read from requester 0
        req_valid = 3'b001; req_addr[31:0] = 32'h8000_0000;
        m_req_ready = 1'b1; resp_ready = 3'b001;
        @(negedge clk);
        check("t1_req_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid = '0; m_resp_valid = 1'b1; m_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t1_m_addr",      64'(m_addr),      64'h8000_0000);
        check("t1_m_req_valid", 64'(m_req_valid), 64'h1);
        check("t1_issue_no_resp", 64'(resp_valid), 64'h0);
        cyc();
        @(negedge clk);
        check("t1_resp_valid", 64'(resp_valid), 64'h1);
        check("t1_resp_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
        cyc();
        m_resp_valid = 1'b0;
        @(negedge clk);
        check("t1_idle", 64'(busy), 64'h0);

        // 2. contention from reset: grants alternate 0,1,0,1
        do_reset();
        req_addr[31:0] = 32'h0000_0100; req_addr[63:32] = 32'h0000_0200;
        req_valid = 3'b011; m_req_ready = 1'b1; m_resp_valid = 1'b1; resp_ready = 3'b011;
        m_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 30 && grants.size() < 4; i++) begin
            @(negedge clk);
            for (int b = 0; b < N; b++) begin
                if (req_ready[b]) grants.push_back(b);
            end
            cyc();
        end
        check("t2_ngrants", 64'(grants.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check("t2_grant", 64'(grants[i]), 64'(exp_grants[i]));
        end
        drain("t2_drain", 20);
        cyc();

        // 3. backpressure on request then response; ptr is 2 so requester 1 wins alone
        req_valid = 3'b010; m_req_ready = 1'b0; m_resp_valid = 1'b0; resp_ready = '0;
        @(negedge clk);
        check("t3_req_ready", 64'(req_ready), 64'h2);
        cyc();
        req_valid = 3'b011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_m_req_valid", 64'(m_req_valid), 64'h1);
            check("t3_m_addr",      64'(m_addr),      64'h200);
            check("t3_no_ready",    64'(req_ready),   64'h0);
            cyc();
        end
        m_req_ready = 1'b1;
        cyc();
        m_req_ready = 1'b0; m_resp_valid = 1'b1; m_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_busy",         64'(busy),         64'h1);
            check("t3_resp_valid",   64'(resp_valid),   64'h2);
            check("t3_m_resp_ready", 64'(m_resp_ready), 64'h0);
            check("t3_no_ready",     64'(req_ready),    64'h0);
            cyc();
        end
        resp_ready = 3'b010;
        @(negedge clk);
        check("t3_m_resp_ready_on", 64'(m_resp_ready), 64'h1);
        cyc();
        m_resp_valid = 1'b0;
        @(negedge clk);
        check("t3_next_winner", 64'(req_ready), 64'h1);
        cyc();
        drain("t3_drain", 20);
        cyc();

        // 4. write from requester 2; pointer then wraps to 0
        req_valid = 3'b100; req_wen = 3'b100; req_addr[95:64] = 32'h0000_0300;
        req_wdata[95:64] = 32'h1234_5678; req_wmask[11:8] = 4'h3;
        m_req_ready = 1'b1; m_resp_valid = 1'b0; resp_ready = 3'b100;
        @(negedge clk);
        check("t4_req_ready", 64'(req_ready), 64'h4);
        cyc();
        req_valid = '0; req_wen = '0;
        @(negedge clk);
        check("t4_m_wen",   64'(m_wen),   64'h1);
        check("t4_m_wmask", 64'(m_wmask), 64'h3);
        check("t4_m_wdata", 64'(m_wdata), 64'h1234_5678);
        check("t4_gnt",     64'(gnt_idx), 64'h2);
        cyc();
        m_resp_valid = 1'b1;
        @(negedge clk);
        check("t4_resp_valid", 64'(resp_valid), 64'h4);
        cyc();
        m_resp_valid = 1'b0; req_valid = 3'b111;
        @(negedge clk);
        check("t4_wrap", 64'(req_ready), 64'h1);
        cyc();
        drain("t4_drain", 20);
        cyc();

        // 5. reset while waiting for a response; ptr is 1 beforehand
        req_valid = 3'b111; m_req_ready = 1'b1; m_resp_valid = 1'b0; resp_ready = '0;
        @(negedge clk);
        check("t5_req_ready", 64'(req_ready), 64'h2);
        cyc();
        req_valid = '0;
        cyc();
        m_resp_valid = 1'b1;
        @(negedge clk);
        check("t5_wait_busy",  64'(busy),       64'h1);
        check("t5_wait_resp",  64'(resp_valid), 64'h2);
        @(posedge clk);
        #2;
        rst_n = 1'b0; req_valid = 3'b111; resp_ready = '1;
        #1;
        check("t5_rst_req_ready",    64'(req_ready),    64'h0);
        check("t5_rst_resp_valid",   64'(resp_valid),   64'h0);
        check("t5_rst_m_req_valid",  64'(m_req_valid),  64'h0);
        check("t5_rst_m_resp_ready", 64'(m_resp_ready), 64'h0);
        check("t5_rst_busy",         64'(busy),         64'h0);
        check("t5_rst_gnt",          64'(gnt_idx),      64'h0);
        check("t5_rst_m_addr",       64'(m_addr),       64'h0);
        check("t5_rst_m_wmask",      64'(m_wmask),      64'h0);
        @(negedge clk);
        cyc();
        rst_n = 1'b1; m_resp_valid = 1'b0;
        @(negedge clk);
        check("t5_post_busy", 64'(busy),      64'h0);
        check("t5_post_ptr",  64'(req_ready), 64'h1);
        cyc();
        drain("t5_drain", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
